// File: rtl/sr_ff_bank.sv
// Bank of WIDTH clocked SR flip-flops with a shared clock-enable.
// S=R=1 resolves per MODE; conflicts are flagged, made sticky and counted.
module sr_ff_bank #(
  parameter int WIDTH = 8,
  parameter int MODE = 0,
  parameter logic [WIDTH-1:0] INIT = '0,
  parameter int CNT_W = 8
) (
  input  logic             C,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic             CLR_ERR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             FORBID,
  output logic             FORBID_STK,
  output logic [CNT_W-1:0] FORBID_CNT
);

  if (MODE < 0 || MODE > 3) begin : g_bad_mode
    $error("sr_ff_bank: MODE must be 0..3");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] r_q;
  logic             r_forbid;
  logic             r_stk;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_both;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_idle;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_conf;
  logic             w_stk_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_both = S & R;
  assign w_set  = S & ~R;
  assign w_idle = ~(S | R);
  assign w_conf = EN & (|w_both);

  // Value a colliding bit takes, chosen by the resolution mode
  always_comb begin
    w_res = r_q;
    case (MODE)
      1:       w_res = '1;
      2:       w_res = '0;
      3:       w_res = ~r_q;
      default: w_res = r_q;
    endcase
  end

  // Per-bit next state plus error flag/counter next values
  always_comb begin
    w_q_nxt   = (r_q & w_idle) | w_set | (w_res & w_both);
    w_stk_nxt = r_stk;
    w_cnt_nxt = r_cnt;
    if (w_conf) begin
      w_stk_nxt = 1'b1;
    end else if (CLR_ERR) begin
      w_stk_nxt = 1'b0;
    end
    if (CLR_ERR) begin
      w_cnt_nxt = {{(CNT_W-1){1'b0}}, w_conf};
    end else if (w_conf && r_cnt != CNT_MAX) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // State register with synchronous reset taking priority over everything
  always_ff @(posedge C) begin
    if (RST) begin
      r_q      <= INIT;
      r_forbid <= 1'b0;
      r_stk    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (EN) begin
        r_q <= w_q_nxt;
      end
      r_forbid <= w_conf;
      r_stk    <= w_stk_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign Q          = r_q;
  assign Qn         = ~r_q;
  assign FORBID     = r_forbid;
  assign FORBID_STK = r_stk;
  assign FORBID_CNT = r_cnt;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Self-checking bench for sr_ff_bank: four MODE instances with an
// 8-bit counter and one MODE 0 instance with a 2-bit counter.
module tb_sr_ff_bank;

  logic       C = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b0;
  logic [7:0] S = '0;
  logic [7:0] R = '0;
  logic       CLR = 1'b0;

  logic [7:0] q[5];
  logic [7:0] qn[5];
  logic       fb[5];
  logic       stk[5];
  logic [7:0] cnt8[4];
  logic [1:0] cnt2;

  logic [7:0] mq[5];
  bit         mf[5];
  bit         ms[5];
  int         mc[5];

  int checks = 0;
  int failures = 0;

  always #5 C = ~C;

  for (genvar m = 0; m < 4; m++) begin : g_mode
    sr_ff_bank #(
      .WIDTH(8), .MODE(m), .INIT(8'hA5), .CNT_W(8)
    ) u_dut (
      .C(C), .RST(RST), .EN(EN), .S(S), .R(R),
      .CLR_ERR(CLR), .Q(q[m]), .Qn(qn[m]),
      .FORBID(fb[m]), .FORBID_STK(stk[m]),
      .FORBID_CNT(cnt8[m])
    );
  end

  sr_ff_bank #(
    .WIDTH(8), .MODE(0), .INIT(8'hA5), .CNT_W(2)
  ) u_sat (
    .C(C), .RST(RST), .EN(EN), .S(S), .R(R),
    .CLR_ERR(CLR), .Q(q[4]), .Qn(qn[4]),
    .FORBID(fb[4]), .FORBID_STK(stk[4]),
    .FORBID_CNT(cnt2)
  );

  function automatic int get_cnt(int k);
    return (k < 4) ? int'(cnt8[k]) : int'(cnt2);
  endfunction

  // Reference model: apply the SR rules to the current inputs, then clock
  task automatic tick();
    bit conf;
    conf = EN && ((S & R) != 8'h00);
    for (int k = 0; k < 5; k++) begin
      int mode;
      int cmax;
      mode = (k < 4) ? k : 0;
      cmax = (k < 4) ? 255 : 3;
      if (RST) begin
        mq[k] = 8'hA5;
        mf[k] = 0;
        ms[k] = 0;
        mc[k] = 0;
      end else begin
        if (EN) begin
          for (int b = 0; b < 8; b++) begin
            if (S[b] && !R[b]) mq[k][b] = 1'b1;
            else if (R[b] && !S[b]) mq[k][b] = 1'b0;
            else if (S[b] && R[b]) begin
              if (mode == 1) mq[k][b] = 1'b1;
              else if (mode == 2) mq[k][b] = 1'b0;
              else if (mode == 3) mq[k][b] = !mq[k][b];
            end
          end
        end
        mf[k] = conf;
        if (conf) ms[k] = 1;
        else if (CLR) ms[k] = 0;
        if (CLR) mc[k] = conf ? 1 : 0;
        else if (conf && mc[k] < cmax) mc[k] = mc[k] + 1;
      end
    end
    @(posedge C);
    #1;
  endtask

  task automatic test_reset();
    RST = 1; EN = 1; S = 8'hFF; R = 8'h0F; CLR = 0;
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (q[k] !== 8'hA5 || qn[k] !== 8'h5A) begin
        failures++;
        $display("FAIL reset_q k=%0d got=%h/%h exp=a5/5a",
                 k, q[k], qn[k]);
      end
      checks++;
      if (fb[k] !== 1'b0 || stk[k] !== 1'b0 || get_cnt(k) != 0) begin
        failures++;
        $display("FAIL reset_err k=%0d got=%b/%b/%0d exp=0/0/0",
                 k, fb[k], stk[k], get_cnt(k));
      end
    end
    RST = 0;
  endtask

  task automatic test_set_reset_mem();
    logic [7:0] exp_q[4];
    exp_q[0] = 8'h00; exp_q[1] = 8'h01;
    exp_q[2] = 8'h00; exp_q[3] = 8'h00;
    for (int st = 0; st < 4; st++) begin
      case (st)
        0: begin EN = 1; S = 8'h00; R = 8'hFF; end
        1: begin EN = 1; S = 8'h01; R = 8'h00; end
        2: begin EN = 1; S = 8'h00; R = 8'h01; end
        default: begin EN = 0; S = 8'hFF; R = 8'h00; end
      endcase
      tick();
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (q[k] !== exp_q[st] || fb[k] !== 1'b0) begin
          failures++;
          $display("FAIL srm st=%0d k=%0d got=%h/%b exp=%h/0",
                   st, k, q[k], fb[k], exp_q[st]);
        end
      end
    end
    EN = 0; S = 0; R = 0;
    tick();
    checks++;
    if (q[0] !== 8'h00) begin
      failures++;
      $display("FAIL mem_hold got=%h exp=00", q[0]);
    end
  endtask

  task automatic test_modes();
    logic [7:0] exp_q[4];
    exp_q[0] = 8'h0F; exp_q[1] = 8'hFF;
    exp_q[2] = 8'h00; exp_q[3] = 8'hF0;
    EN = 1; S = 8'h0F; R = 8'hF0; CLR = 1;
    tick();
    CLR = 0; S = 8'hFF; R = 8'hFF;
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (q[k] !== exp_q[k] || qn[k] !== ~exp_q[k]) begin
        failures++;
        $display("FAIL mode_q m=%0d got=%h exp=%h", k, q[k], exp_q[k]);
      end
      checks++;
      if (fb[k] !== 1'b1 || stk[k] !== 1'b1 || get_cnt(k) != 1) begin
        failures++;
        $display("FAIL mode_err m=%0d got=%b/%b/%0d exp=1/1/1",
                 k, fb[k], stk[k], get_cnt(k));
      end
    end
    S = 0; R = 0;
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (fb[k] !== 1'b0 || stk[k] !== 1'b1 || get_cnt(k) != 1) begin
        failures++;
        $display("FAIL mode_after m=%0d got=%b/%b/%0d exp=0/1/1",
                 k, fb[k], stk[k], get_cnt(k));
      end
    end
  endtask

  task automatic test_saturation();
    int exp_c[5] = '{1, 2, 3, 3, 3};
    RST = 1; tick(); RST = 0;
    EN = 1; CLR = 0;
    for (int i = 0; i < 5; i++) begin
      S = 8'h80; R = 8'h81;
      tick();
      checks++;
      if (int'(cnt2) != exp_c[i] || fb[4] !== 1'b1) begin
        failures++;
        $display("FAIL sat i=%0d got=%0d/%b exp=%0d/1",
                 i, cnt2, fb[4], exp_c[i]);
      end
    end
    S = 0; R = 0;
    tick();
    checks++;
    if (fb[4] !== 1'b0 || cnt2 !== 2'd3) begin
      failures++;
      $display("FAIL sat_end got=%b/%0d exp=0/3", fb[4], cnt2);
    end
  endtask

  task automatic test_clear_vs_conflict();
    EN = 1; S = 0; R = 0; CLR = 1;
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (stk[k] !== 1'b0 || get_cnt(k) != 0) begin
        failures++;
        $display("FAIL clr k=%0d got=%b/%0d exp=0/0",
                 k, stk[k], get_cnt(k));
      end
    end
    CLR = 0; S = 8'h10; R = 8'h10;
    tick(); tick(); tick();
    CLR = 1; EN = 0;
    tick();
    checks++;
    if (stk[4] !== 1'b0 || cnt2 !== 2'd0 || q[4] !== mq[4]) begin
      failures++;
      $display("FAIL clr_noen got=%b/%0d exp=0/0", stk[4], cnt2);
    end
    EN = 1;
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (stk[k] !== 1'b1 || get_cnt(k) != 1) begin
        failures++;
        $display("FAIL clr_conf k=%0d got=%b/%0d exp=1/1",
                 k, stk[k], get_cnt(k));
      end
    end
    CLR = 0; S = 0; R = 0;
  endtask

  task automatic test_reset_priority();
    EN = 1; S = 8'hFF; R = 8'hFF; CLR = 1; RST = 1;
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (q[k] !== 8'hA5 || fb[k] !== 1'b0 ||
          stk[k] !== 1'b0 || get_cnt(k) != 0) begin
        failures++;
        $display("FAIL rst_prio k=%0d got=%h/%b/%b/%0d exp=a5/0/0/0",
                 k, q[k], fb[k], stk[k], get_cnt(k));
      end
    end
    RST = 0; CLR = 0; S = 0; R = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      RST = ($urandom_range(0, 39) == 0);
      EN  = ($urandom_range(0, 3) != 0);
      CLR = ($urandom_range(0, 9) == 0);
      S = 8'($urandom);
      R = 8'($urandom);
      if ($urandom_range(0, 1) == 0) R = R & ~S;
      tick();
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (q[k] !== mq[k] || qn[k] !== ~mq[k] ||
            fb[k] !== mf[k] || stk[k] !== ms[k] ||
            get_cnt(k) != mc[k]) begin
          failures++;
          $display("FAIL rnd i=%0d k=%0d got=%h/%b/%b/%0d exp=%h/%b/%b/%0d",
                   i, k, q[k], fb[k], stk[k], get_cnt(k),
                   mq[k], mf[k], ms[k], mc[k]);
        end
      end
    end
    RST = 0; CLR = 0;
  endtask

  initial begin
    for (int k = 0; k < 5; k++) begin
      mq[k] = 8'h00; mf[k] = 0; ms[k] = 0; mc[k] = 0;
    end
    test_reset();
    test_set_reset_mem();
    test_modes();
    test_saturation();
    test_clear_vs_conflict();
    test_reset_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
